// File: rtl/cam_pkg.sv
// Shared camera-path types and constants: pixel format, frame geometry,
// blob-tracker state, accumulator and result payloads.
package cam_pkg;

    localparam int unsigned FRAME_W = 320;
    localparam int unsigned FRAME_H = 240;
    localparam int unsigned ADDR_W  = 17;
    localparam int unsigned X_W     = 9;
    localparam int unsigned Y_W     = 8;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        REPORT
    } blob_state_t;

    // Per-frame running statistics
    typedef struct packed {
        logic [X_W-1:0]    x;
        logic [Y_W-1:0]    y;
        logic [ADDR_W-1:0] cnt;
        logic [ADDR_W-1:0] total;
        logic [X_W-1:0]    xmin;
        logic [X_W-1:0]    xmax;
        logic [Y_W-1:0]    ymin;
        logic [Y_W-1:0]    ymax;
    } blob_acc_t;

    // Reported frame result
    typedef struct packed {
        logic              found;
        logic [ADDR_W-1:0] count;
        logic [X_W-1:0]    xmin;
        logic [X_W-1:0]    xmax;
        logic [Y_W-1:0]    ymin;
        logic [Y_W-1:0]    ymax;
        logic              err;
    } blob_result_t;

    // Bounding box starts inverted so the first match sets it
    localparam blob_acc_t ACC_CLR = '{
        x: '0, y: '0, cnt: '0, total: '0,
        xmin: '1, xmax: '0, ymin: '1, ymax: '0
    };

endpackage

// File: rtl/colour_blob_tracker_if.sv
// Pixel-write snoop stream in, per-frame blob statistics out.
interface colour_blob_tracker_if;
    import cam_pkg::*;

    logic              vsync;
    logic              we;
    logic [11:0]       pixel;
    logic              blob_valid;
    logic              blob_found;
    logic [ADDR_W-1:0] blob_count;
    logic [X_W-1:0]    x_min;
    logic [X_W-1:0]    x_max;
    logic [Y_W-1:0]    y_min;
    logic [Y_W-1:0]    y_max;
    logic              frame_err;

    modport master (
        output vsync, we, pixel,
        input  blob_valid, blob_found, blob_count,
        input  x_min, x_max, y_min, y_max, frame_err
    );

    modport slave (
        input  vsync, we, pixel,
        output blob_valid, blob_found, blob_count,
        output x_min, x_max, y_min, y_max, frame_err
    );

endinterface

// File: rtl/colour_blob_tracker_match.sv
// Combinational red-dominance classifier for one RGB444 pixel; the compare
// is done at 5 bits so the margin add never wraps.
module colour_match
    import cam_pkg::*;
(
    input  rgb444_t    px,
    input  logic [3:0] r_min,
    input  logic [3:0] margin,
    output logic       match_c
);

    logic [4:0] r_ext;
    logic [4:0] g_lim;
    logic [4:0] b_lim;

    always_comb begin
        r_ext   = {1'b0, px.r};
        g_lim   = {1'b0, px.g} + {1'b0, margin};
        b_lim   = {1'b0, px.b} + {1'b0, margin};
        match_c = (px.r >= r_min) && (r_ext >= g_lim) && (r_ext >= b_lim);
    end

endmodule

// File: rtl/colour_blob_tracker.sv
// Per-frame colour-blob statistics on the camera pixel-write stream:
// match count, bounding box and pixel-total integrity, reported at vsync rise.
module colour_blob_tracker
    import cam_pkg::*;
#(
    parameter int unsigned WIDTH  = FRAME_W,
    parameter int unsigned HEIGHT = FRAME_H,
    parameter int unsigned R_MIN  = 8,
    parameter int unsigned MARGIN = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    colour_blob_tracker_if.slave   bus
);

    localparam logic [ADDR_W-1:0] FRAME_PIX = ADDR_W'(WIDTH * HEIGHT);
    localparam logic [X_W-1:0]    X_LAST    = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(HEIGHT - 1);

    blob_state_t  state_q, state_d;
    blob_acc_t    acc_q, acc_d;
    blob_result_t res_q, res_d;
    logic         vsync_q, vsync_d;
    logic         pend_q, pend_d;
    logic         blob_valid_q, blob_valid_d;

    rgb444_t      px_c;
    logic         match_c;
    logic         pix_en_c;
    logic         rise_c;
    logic         in_range_c;

    assign px_c = rgb444_t'(bus.pixel);

    colour_match u_match (
        .px      (px_c),
        .r_min   (4'(R_MIN)),
        .margin  (4'(MARGIN)),
        .match_c (match_c)
    );

    // Next-state, accumulation and result capture
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        res_d        = res_q;
        vsync_d      = bus.vsync;
        pend_d       = pend_q;
        blob_valid_d = (state_q == REPORT);
        pix_en_c     = bus.we && !bus.vsync;
        rise_c       = bus.vsync && !vsync_q;
        in_range_c   = (acc_q.total < FRAME_PIX);

        if (pix_en_c) begin
            acc_d.total = (acc_q.total == '1) ? acc_q.total : acc_q.total + ADDR_W'(1);
            if (acc_q.x == X_LAST) begin
                acc_d.x = '0;
                if (acc_q.y != Y_LAST) begin
                    acc_d.y = acc_q.y + Y_W'(1);
                end
            end else begin
                acc_d.x = acc_q.x + X_W'(1);
            end
            // Overflow pixels past a full frame only count toward the total
            if (in_range_c && match_c) begin
                acc_d.cnt  = (acc_q.cnt == '1) ? acc_q.cnt : acc_q.cnt + ADDR_W'(1);
                acc_d.xmin = (acc_q.x < acc_q.xmin) ? acc_q.x : acc_q.xmin;
                acc_d.xmax = (acc_q.x > acc_q.xmax) ? acc_q.x : acc_q.xmax;
                acc_d.ymin = (acc_q.y < acc_q.ymin) ? acc_q.y : acc_q.ymin;
                acc_d.ymax = (acc_q.y > acc_q.ymax) ? acc_q.y : acc_q.ymax;
            end
        end

        unique case (state_q)
            IDLE: begin
                acc_d  = ACC_CLR;
                pend_d = 1'b0;
                if (rise_c) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (rise_c || pend_q) begin
                    state_d     = REPORT;
                    pend_d      = 1'b0;
                    res_d.found = (acc_d.cnt != '0);
                    res_d.count = acc_d.cnt;
                    res_d.err   = (acc_d.total != FRAME_PIX);
                    if (acc_d.cnt != '0) begin
                        res_d.xmin = acc_d.xmin;
                        res_d.xmax = acc_d.xmax;
                        res_d.ymin = acc_d.ymin;
                        res_d.ymax = acc_d.ymax;
                    end else begin
                        res_d.xmin = '0;
                        res_d.xmax = '0;
                        res_d.ymin = '0;
                        res_d.ymax = '0;
                    end
                    acc_d = ACC_CLR;
                end
            end
            REPORT: begin
                state_d = ACTIVE;
                pend_d  = rise_c;
            end
            default: begin
                state_d = IDLE;
                acc_d   = ACC_CLR;
                pend_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            acc_q        <= ACC_CLR;
            res_q        <= '0;
            vsync_q      <= 1'b0;
            pend_q       <= 1'b0;
            blob_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            res_q        <= res_d;
            vsync_q      <= vsync_d;
            pend_q       <= pend_d;
            blob_valid_q <= blob_valid_d;
        end
    end

    assign bus.blob_valid = blob_valid_q;
    assign bus.blob_found = res_q.found;
    assign bus.blob_count = res_q.count;
    assign bus.x_min      = res_q.xmin;
    assign bus.x_max      = res_q.xmax;
    assign bus.y_min      = res_q.ymin;
    assign bus.y_max      = res_q.ymax;
    assign bus.frame_err  = res_q.err;

endmodule
